boot_rom_bus_bridge: RTL and testbench

//  Data-bus slave bridge that consumes the boot ROM's read port and exposes it to the core/interconnect

---
 rtl/boot_rom_bridge_pkg.sv | 13 +
 rtl/boot_rom_rsp_fifo.sv | 58 +++++
 rtl/boot_rom_bus_bridge.sv | 105 ++++++++++
 tb/tb_boot_rom_bus_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_rom_bridge_pkg.sv
// Shared types for the boot ROM bus bridge: the response payload carried from ROM to consumer.
package boot_rom_bridge_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    localparam logic [DATA_W-1:0] ERR_RDATA = '0;

endpackage

// File: rtl/boot_rom_rsp_fifo.sv
// Small in-order response buffer that lets the consumer stall without losing ROM read data.
module boot_rom_rsp_fifo
    import boot_rom_bridge_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  rsp_t             data_in,
    input  logic             pop,
    output rsp_t             head,
    output logic [CNT_W-1:0] occ,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occ and the pointers alone decide which entries are live.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    assign head  = mem[rd_ptr];
    assign empty = (occ == '0);
    assign full  = (occ == CNT_W'(DEPTH));

    // The upstream credit check must make this impossible.
    assert property (@(posedge CLK) disable iff (RST) push |-> !full)
        else $error("response buffer overflow");

endmodule

// File: rtl/boot_rom_bus_bridge.sv
// req/gnt/rvalid slave in front of the boot ROM: address decode, ROM strobe, latency-1 read return
// with a bypass path and a credit-limited response buffer for consumer back-pressure.
module boot_rom_bus_bridge
    import boot_rom_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROM_WORDS  = 548,
    parameter int                    ROM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_8000,
    parameter int                    RSP_DEPTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  rom_csn_o,
    output logic [ROM_AW-1:0]     rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_q_i
);

    localparam int                    CNT_W       = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-3:0] ROM_WORDS_W = (ADDR_WIDTH - 2)'(ROM_WORDS);

    logic [ADDR_WIDTH-1:0] off;
    logic                  ok;
    logic                  access;
    logic                  inflight_q;
    logic                  ok_q;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W:0]        used;
    logic                  empty;
    logic                  push;
    logic                  pop;
    rsp_t                  payload;
    rsp_t                  head;
    rsp_t                  out;
    logic                  unused_bits;

    // Wrapping subtraction; the >= BASE_ADDR term rejects addresses that wrap into range.
    assign off = addr_i - BASE_ADDR;
    assign ok  = ~we_i & (addr_i[1:0] == 2'b00) & (addr_i >= BASE_ADDR)
               & (off[ADDR_WIDTH-1:2] < ROM_WORDS_W);

    // A grant reserves a buffer slot, so a later push can never find the buffer full.
    assign used  = {1'b0, occ} + (CNT_W + 1)'(inflight_q);
    assign gnt_o = req_i & ~RST & (used < (CNT_W + 1)'(RSP_DEPTH));

    assign access     = gnt_o & ok;
    assign rom_csn_o  = ~access;
    assign rom_addr_o = access ? off[ROM_AW+1:2] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            inflight_q <= gnt_o;
            ok_q       <= access;
        end
    end

    always_comb begin
        payload.data = ERR_RDATA;
        payload.err  = 1'b1;
        if (ok_q) begin
            payload.data = rom_q_i;
            payload.err  = 1'b0;
        end
    end

    // Empty buffer: the fresh payload goes straight out; otherwise it queues behind the head.
    assign push = inflight_q & (~empty | ~rready_i);
    assign pop  = ~empty & rready_i;

    boot_rom_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .data_in (payload),
        .pop     (pop),
        .head    (head),
        .occ     (occ),
        .empty   (empty)
    );

    assign out      = empty ? payload : head;
    assign rvalid_o = inflight_q | ~empty;
    assign rdata_o  = rvalid_o ? out.data : '0;
    assign err_o    = rvalid_o & out.err;

    assign unused_bits = ^{be_i, wdata_i, off[1:0]};

endmodule

// File: tb/tb_boot_rom_bus_bridge.sv
// Directed bench for boot_rom_bus_bridge: issued reads push expected responses, a negedge monitor pops them.
module tb_boot_rom_bus_bridge;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic        err;
    logic        rom_csn;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q = '0;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [32:0] exp_q [$];
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_err = 1'b0;
    int          waited;

    always #5 CLK = ~CLK;

    boot_rom_bus_bridge dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .rdata_o    (rdata),
        .err_o      (err),
        .rom_csn_o  (rom_csn),
        .rom_addr_o (rom_addr),
        .rom_q_i    (rom_q)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        case (idx)
            10'd0:         return 32'h0000_0013;
            10'd31, 10'd32: return 32'h0100_006F;
            default:       return {16'hC0DE, 6'b0, idx};
        endcase
    endfunction

    // ROM model with a registered address.
    always @(posedge CLK) begin
        if (!rom_csn) rom_q <= rom_word(rom_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [32:0] e;
        if (!RST) begin
            if (hold) begin
                check("hold_rvalid", {31'b0, rvalid}, 32'd1);
                check("hold_rdata", rdata, hold_data);
                check("hold_err", {31'b0, err}, {31'b0, hold_err});
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e[32:1]);
                    check("err", {31'b0, err}, {31'b0, e[0]});
                end
            end
        end
        hold      = !RST && rvalid && !rready;
        hold_data = rdata;
        hold_err  = err;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic exp_ok,
                         input logic [31:0] exp_data, output int wait_cycles);
        bit done = 1'b0;
        wait_cycles = 0;
        req  = 1'b1;
        addr = a;
        we   = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (gnt) begin
                done = 1'b1;
                check("rom_csn", {31'b0, rom_csn}, {31'b0, !exp_ok});
                if (exp_ok) check("rom_addr", {22'b0, rom_addr}, (a - 32'h8000) >> 2);
                exp_q.push_back(exp_ok ? {exp_data, 1'b0} : {32'b0, 1'b1});
            end else begin
                wait_cycles++;
            end
            step();
        end
        if (!done) check("gnt_timeout", {31'b0, gnt}, 32'd1);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_csn"}, {31'b0, rom_csn}, 32'd1);
        check({tag, "_rom_addr"}, {22'b0, rom_addr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state, with req held high to confirm gnt is masked.
        req = 1'b1;
        repeat (2) step();
        @(negedge CLK);
        check("reset_gnt", {31'b0, gnt}, 32'd0);
        check_reset_outputs("reset");
        step();
        req = 1'b0;
        RST = 1'b0;
        step();

        // 1: single read, latency 1.
        issue(32'h0000_8000, 1'b0, 1'b1, 32'h0000_0013, waited);
        @(negedge CLK);
        check("t1_latency_rvalid", {31'b0, rvalid}, 32'd1);
        step();
        drain();

        // 2: back-to-back reads, no grant stalls.
        issue(32'h0000_807C, 1'b0, 1'b1, 32'h0100_006F, waited);
        check("t2_wait0", waited, 32'd0);
        issue(32'h0000_8080, 1'b0, 1'b1, 32'h0100_006F, waited);
        check("t2_wait1", waited, 32'd0);
        drain();

        // 3: consumer stall fills the credit window, then drains in order.
        rready = 1'b0;
        issue(32'h0000_8000, 1'b0, 1'b1, 32'h0000_0013, waited);
        issue(32'h0000_8004, 1'b0, 1'b1, 32'hC0DE_0001, waited);
        check("t3_second_gnt", waited, 32'd0);
        req  = 1'b1;
        addr = 32'h0000_8008;
        @(negedge CLK);
        check("t3_gnt_full_a", {31'b0, gnt}, 32'd0);
        check("t3_rvalid_held", {31'b0, rvalid}, 32'd1);
        step();
        @(negedge CLK);
        check("t3_gnt_full_b", {31'b0, gnt}, 32'd0);
        step();
        req    = 1'b0;
        rready = 1'b1;
        drain();

        // 4: write, misaligned, one past the last word.
        issue(32'h0000_8000, 1'b1, 1'b0, 32'h0, waited);
        issue(32'h0000_8003, 1'b0, 1'b0, 32'h0, waited);
        issue(32'h0000_8890, 1'b0, 1'b0, 32'h0, waited);
        drain();

        // 5: below base and high-bit alias.
        issue(32'h0000_7FFC, 1'b0, 1'b0, 32'h0, waited);
        issue(32'h1000_8000, 1'b0, 1'b0, 32'h0, waited);
        drain();

        // 6: reset with one entry buffered and one in flight.
        rready = 1'b0;
        issue(32'h0000_8000, 1'b0, 1'b1, 32'h0000_0013, waited);
        issue(32'h0000_8004, 1'b0, 1'b1, 32'hC0DE_0001, waited);
        RST  = 1'b1;
        req  = 1'b1;
        addr = 32'h0000_8008;
        @(negedge CLK);
        check("t6_gnt_in_reset", {31'b0, gnt}, 32'd0);
        exp_q.delete();
        step();
        req    = 1'b0;
        RST    = 1'b0;
        rready = 1'b1;
        @(negedge CLK);
        check_reset_outputs("t6_post");
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            check("t6_no_stale", {31'b0, rvalid}, 32'd0);
        end
        step();
        issue(32'h0000_8004, 1'b0, 1'b1, 32'hC0DE_0001, waited);
        @(negedge CLK);
        check("t6_latency_rvalid", {31'b0, rvalid}, 32'd1);
        step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
